md_unit: RTL

- Multi-cycle multiply/divide unit in the E stage of the pipelined CPU. Holds the HI/LO registers and runs MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Produces the busy/stall side of the stall interface. The hazard unit consumes stall_md and ORs it into pc_enabled, IF_to_D_enabled and reset_D_to_E.
- MFHI/MFLO read hi/lo combinationally in E. They are forwarded like any T_new_E==0 producer.

---
 rtl/md_pkg.sv | 32 +++
 rtl/md_div_core.sv | 42 ++++
 rtl/md_unit.sv | 120 ++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared encodings and defaults for the multiply/divide unit.
package md_pkg;

    localparam int unsigned OP_W   = 3;
    localparam int unsigned DATA_W = 32;

    localparam logic [OP_W-1:0] MD_NONE  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULT  = 3'd1;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd2;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd3;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd5;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd6;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Result pair waiting to be committed to HI/LO.
    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } md_result_t;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic is_md_calc(input logic [OP_W-1:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_div_core.sv
// Combinational 32-bit signed/unsigned divider with MIPS-style corner cases.
module md_div_core
    import md_pkg::*;
(
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic [31:0] quo_c,
    output logic [31:0] rem_c
);

    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] safe_b;
    logic [31:0] uq;
    logic [31:0] ur;

    assign neg_a  = is_signed & dividend[31];
    assign neg_b  = is_signed & divisor[31];
    assign abs_a  = neg_a ? (32'd0 - dividend) : dividend;
    assign abs_b  = neg_b ? (32'd0 - divisor) : divisor;
    // Avoid an X-producing divide by zero; the zero case is overridden below.
    assign safe_b = (divisor == 32'd0) ? 32'd1 : abs_b;
    assign uq     = abs_a / safe_b;
    assign ur     = abs_a % safe_b;

    // Sign fix-up and special cases: quotient truncates toward zero, remainder follows dividend.
    always_comb begin
        quo_c = (neg_a ^ neg_b) ? (32'd0 - uq) : uq;
        rem_c = neg_a ? (32'd0 - ur) : ur;
        if (divisor == 32'd0) begin
            quo_c = 32'hFFFF_FFFF;
            rem_c = dividend;
        end else if (is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF)) begin
            quo_c = 32'h8000_0000;
            rem_c = 32'd0;
        end
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, runs fixed-latency mult/div, raises stall_md.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = (MAX_CYCLES < 2) ? 1 : $clog2(MAX_CYCLES + 1);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_result_t       hold_q, hold_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic             busy_q;

    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] div_quo;
    logic        [31:0] div_rem;

    assign prod_s = $signed({{32{rs_data[31]}}, rs_data}) * $signed({{32{rt_data[31]}}, rt_data});
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    md_div_core u_div (
        .dividend  (rs_data),
        .divisor   (rt_data),
        .is_signed (md_op == MD_DIV),
        .quo_c     (div_quo),
        .rem_c     (div_rem)
    );

    // State, countdown, held result and HI/LO registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= (state_d == ST_RUN);
        end
    end

    // Next-state: issue from IDLE, count down in RUN, commit the held result on the last cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (md_op)
                        MD_MULT: begin
                            hold_d.hi = prod_s[63:32];
                            hold_d.lo = prod_s[31:0];
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_MULTU: begin
                            hold_d.hi = prod_u[63:32];
                            hold_d.lo = prod_u[31:0];
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            hold_d.hi = div_rem;
                            hold_d.lo = div_quo;
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = ST_RUN;
                        end
                        MD_MTHI: hi_d = rs_data;
                        MD_MTLO: lo_d = rs_data;
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = hold_q.hi;
                    lo_d    = hold_q.lo;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stall the D-stage md instruction while busy or while an op is issuing this cycle.
    assign stall_md = md_use_D & (busy_q | (start & is_md_calc(md_op)));

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
